pipe_hazard_ctrl: RTL

- Pipeline sequencer for the fetch/decode front end of the KGP-RISC core.
- Generates the write-enable and flush controls for the PC and the IF/ID register, and the bubble control for the ID/EX register.
- Generates a global freeze for the EX/MEM/WB stages.
- Resolves four hazard sources: load-use, taken branch, busy memory, and HALT/resume. Also keeps a saturating stall-cycle counter.

---
 rtl/kgp_pipe_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/load_use_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/kgp_pipe_pkg.sv
// Shared types and constants for the KGP-RISC front-end hazard control.
package kgp_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    HALTED   = 2'd3
  } pipe_state_e;

  localparam int unsigned ISA_REG_W   = 5;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned FLUSH_CTR_W = 2;

  localparam logic [ISA_REG_W-1:0] REG_ZERO  = '0;
  localparam logic [INSTR_W-1:0]   NOP_INSTR = 32'b0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus: ID/EX hazard inputs toward the controller, pipeline
// enables and status back to the datapath.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             id_halt;
  logic             resume;

  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             freeze;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rd,
           ex_branch_taken, mem_busy, id_halt, resume,
    input  pc_we, if_id_we, if_id_flush, id_ex_bubble, freeze, halted,
           stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rd,
           ex_branch_taken, mem_busy, id_halt, resume,
    output pc_we, if_id_we, if_id_flush, id_ex_bubble, freeze, halted,
           stall_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use detector: the EX load writes a register that the ID
// instruction reads. Writes to the zero register never create a hazard.
module load_use_detect
  import kgp_pipe_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             lu
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = id_uses_rs && (id_rs == ex_rd);
    rt_hit = id_uses_rt && (id_rt == ex_rd);
    lu     = ex_memread && (ex_rd != REG_W'(REG_ZERO)) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end pipeline sequencer: Mealy decode of PC / IF/ID / ID/EX controls
// and back-end freeze, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import kgp_pipe_pkg::*;
#(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input logic          clk,
  input logic          reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [FLUSH_CTR_W-1:0] FLUSH_RELOAD = FLUSH_CTR_W'(FLUSH_CYCLES - 1);

  pipe_state_e             state, state_nxt, ret_state, ret_nxt, eff_state;
  logic [FLUSH_CTR_W-1:0]  flush_ctr, flush_nxt;
  logic [CNT_W-1:0]        stall_cnt;
  logic                    lu, stall_inc;
  logic                    pc_we, if_id_we, if_id_flush, id_ex_bubble, freeze, halted;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rs (bus.id_uses_rs),
    .id_uses_rt (bus.id_uses_rt),
    .ex_memread (bus.ex_memread),
    .ex_rd      (bus.ex_rd),
    .lu         (lu)
  );

  // Once memory is ready, MEM_WAIT behaves exactly like the state it returns to.
  always_comb begin
    eff_state    = (state == MEM_WAIT && !bus.mem_busy) ? ret_state : state;
    state_nxt    = eff_state;
    ret_nxt      = ret_state;
    flush_nxt    = flush_ctr;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    freeze       = 1'b0;
    halted       = 1'b0;

    unique case (eff_state)
      RUN: begin
        if (bus.mem_busy) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
          ret_nxt   = RUN;
        end else if (bus.ex_branch_taken) begin
          pc_we        = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            flush_nxt = FLUSH_RELOAD;
          end
        end else if (lu) begin
          id_ex_bubble = 1'b1;
        end else if (bus.id_halt) begin
          id_ex_bubble = 1'b1;
          state_nxt    = HALTED;
        end else begin
          pc_we    = 1'b1;
          if_id_we = 1'b1;
        end
      end
      FLUSH: begin
        if (bus.mem_busy) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
          ret_nxt   = FLUSH;
        end else begin
          pc_we        = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (bus.ex_branch_taken) begin
            flush_nxt = FLUSH_RELOAD;
          end else if (flush_ctr == FLUSH_CTR_W'(1)) begin
            flush_nxt = '0;
            state_nxt = RUN;
          end else begin
            flush_nxt = flush_ctr - FLUSH_CTR_W'(1);
          end
        end
      end
      HALTED: begin
        halted       = 1'b1;
        id_ex_bubble = 1'b1;
        if (bus.resume) begin
          pc_we       = 1'b1;
          if_id_flush = 1'b1;
          state_nxt   = RUN;
        end
      end
      default: begin
        freeze = 1'b1;
      end
    endcase

    if (!reset) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      freeze       = 1'b0;
      halted       = 1'b0;
    end

    stall_inc = reset && !pc_we && (state != HALTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      ret_state <= RUN;
      flush_ctr <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      flush_ctr <= flush_nxt;
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.if_id_we     = if_id_we;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.freeze       = freeze;
  assign bus.halted       = halted;
  assign bus.stall_cnt    = stall_cnt;

endmodule
